// File: rtl/fire9_expand1_ofm_writer_pkg.sv
// Shared types and sizing for the fire9 expand-1x1 output feature-map writer.
package fire9_pkg;

  localparam int WOUT   = 8;
  localparam int DSP_NO = 368;
  localparam int WIDTH  = 16;
  localparam int LANES  = 4;

  localparam int BEATS  = DSP_NO / LANES;
  localparam int NPIX   = WOUT * WOUT;
  localparam int ADDR_W = $clog2(NPIX * BEATS);
  localparam int BEAT_W = $clog2(BEATS);
  localparam int PIX_W  = $clog2(NPIX + 1);
  localparam int CH_W   = $clog2(DSP_NO);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_t;

endpackage

// File: rtl/fire9_expand1_ofm_writer_ofm_lane_mux.sv
// Selects one LANES-wide RAM word out of a channel bank; lane k carries
// channel beat*LANES+k.
module ofm_lane_mux
  import fire9_pkg::*;
(
  input  logic [WIDTH-1:0]       i_bank [0:DSP_NO-1],
  input  logic [BEAT_W-1:0]      i_beat,
  output logic [LANES*WIDTH-1:0] o_word
);

  logic [CH_W-1:0] w_idx;

  // Gather LANES consecutive channels starting at beat*LANES.
  always_comb begin
    o_word = '0;
    w_idx  = '0;
    for (int k = 0; k < LANES; k++) begin
      w_idx = CH_W'(i_beat) * CH_W'(LANES) + CH_W'(k);
      o_word[k*WIDTH +: WIDTH] = i_bank[w_idx];
    end
  end

endmodule

// File: rtl/fire9_expand1_ofm_writer.sv
// Drains the fire9 expand-1x1 output bank into the OFM RAM, one pixel of
// BEATS words per accepted sample, and raises ram_feedback after the last pixel.
//
// state   | meaning
// IDLE    | waiting for the next sample strobe
// WRITE   | streaming the shadow bank, one word per cycle
// DONE    | all pixels written; feedback held until reset
module fire9_expand1_ofm_writer
  import fire9_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_fire9_expand1_sample,
  input  logic [WIDTH-1:0]       i_ofm [0:DSP_NO-1],
  output logic [ADDR_W-1:0]      o_ram_addr,
  output logic [LANES*WIDTH-1:0] o_ram_wdata,
  output logic                   o_ram_we,
  output logic                   o_ram_feedback,
  output logic                   o_busy,
  output logic                   o_overrun
);

  wr_state_t         r_state;
  logic [BEAT_W-1:0] r_beat;
  logic [PIX_W-1:0]  r_pix_cnt;
  logic [ADDR_W-1:0] r_base;
  logic [WIDTH-1:0]  r_shadow [0:DSP_NO-1];

  logic                   w_last_beat;
  logic [PIX_W-1:0]       w_pix_next;
  logic                   w_last_pix;
  logic [ADDR_W-1:0]      w_base_next;
  logic [BEAT_W-1:0]      w_beat_next;
  logic                   w_capture;
  logic [LANES*WIDTH-1:0] w_shadow_word;
  logic [LANES*WIDTH-1:0] w_first_word;

  assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
  assign w_pix_next  = r_pix_cnt + PIX_W'(1);
  assign w_last_pix  = (w_pix_next == PIX_W'(NPIX));
  assign w_base_next = r_base + ADDR_W'(BEATS);
  assign w_beat_next = r_beat + BEAT_W'(1);

  // A capture happens from IDLE, or back-to-back on the final beat unless the
  // pixel just finished is the last one.
  assign w_capture = i_fire9_expand1_sample &&
                     ((r_state == ST_IDLE) ||
                      ((r_state == ST_WRITE) && w_last_beat && !w_last_pix));

  // Next word from the shadow bank while draining.
  ofm_lane_mux u_mux_shadow (
    .i_bank (r_shadow),
    .i_beat (w_beat_next),
    .o_word (w_shadow_word)
  );

  // Beat 0 comes straight from the live bank, since the shadow loads on the same edge.
  ofm_lane_mux u_mux_first (
    .i_bank (i_ofm),
    .i_beat ('0),
    .o_word (w_first_word)
  );

  // Shadow bank holds pure data and only loads on an accepted capture.
  always_ff @(posedge i_clk) begin
    if (w_capture) r_shadow <= i_ofm;
  end

  // Sequencing FSM with registered RAM-side outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      r_beat         <= '0;
      r_pix_cnt      <= '0;
      r_base         <= '0;
      o_ram_addr     <= '0;
      o_ram_wdata    <= '0;
      o_ram_we       <= 1'b0;
      o_ram_feedback <= 1'b0;
      o_busy         <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_fire9_expand1_sample) begin
            r_state     <= ST_WRITE;
            r_beat      <= '0;
            o_ram_we    <= 1'b1;
            o_busy      <= 1'b1;
            o_ram_addr  <= r_base;
            o_ram_wdata <= w_first_word;
          end
        end
        ST_WRITE: begin
          if (!w_last_beat) begin
            r_beat      <= w_beat_next;
            o_ram_addr  <= o_ram_addr + ADDR_W'(1);
            o_ram_wdata <= w_shadow_word;
            if (i_fire9_expand1_sample) o_overrun <= 1'b1;
          end else begin
            r_pix_cnt <= w_pix_next;
            r_base    <= w_base_next;
            if (w_last_pix) begin
              r_state        <= ST_DONE;
              o_ram_we       <= 1'b0;
              o_busy         <= 1'b0;
              o_ram_feedback <= 1'b1;
            end else if (i_fire9_expand1_sample) begin
              r_beat      <= '0;
              o_ram_addr  <= w_base_next;
              o_ram_wdata <= w_first_word;
            end else begin
              r_state  <= ST_IDLE;
              o_ram_we <= 1'b0;
              o_busy   <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fire9_expand1_ofm_writer.sv
// Randomized bench for the fire9 expand-1x1 OFM writer with a queue-based
// reference model of the expected RAM write stream.
module tb_fire9_expand1_ofm_writer;
  import fire9_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   sample = 1'b0;
  logic [WIDTH-1:0]       ofm [0:DSP_NO-1];
  logic [ADDR_W-1:0]      ram_addr;
  logic [LANES*WIDTH-1:0] ram_wdata;
  logic                   ram_we;
  logic                   ram_feedback;
  logic                   busy;
  logic                   overrun;

  always #5 clk = ~clk;

  fire9_expand1_ofm_writer dut (
    .i_clk                  (clk),
    .i_rst_n                (rst_n),
    .i_fire9_expand1_sample (sample),
    .i_ofm                  (ofm),
    .o_ram_addr             (ram_addr),
    .o_ram_wdata            (ram_wdata),
    .o_ram_we               (ram_we),
    .o_ram_feedback         (ram_feedback),
    .o_busy                 (busy),
    .o_overrun              (overrun)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: every accepted sample appends one pixel's worth of
  // (address, word) pairs; the DUT must then present them one per cycle.
  typedef struct {
    int          addr;
    logic [63:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   m_left;
  int   m_acc;
  int   m_done_pix;
  bit   m_fb;
  bit   m_ovr;
  bit   m_pres;
  bit   m_fin;
  logic [63:0] m_word;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_left     = 0;
      m_acc      = 0;
      m_done_pix = 0;
      m_fb       = 1'b0;
      m_ovr      = 1'b0;
    end else begin
      m_pres = (m_left > 0);
      m_fin  = (m_left == 1);
      if (m_pres) m_left--;
      if (m_fin) begin
        m_done_pix++;
        if (m_done_pix == NPIX) m_fb = 1'b1;
      end
      if (sample && !m_fb) begin
        if (!m_pres || m_fin) begin
          for (int b = 0; b < BEATS; b++) begin
            m_word = '0;
            for (int k = 0; k < LANES; k++) m_word[k*WIDTH +: WIDTH] = ofm[b*LANES + k];
            exp_q.push_back('{addr: m_acc * BEATS + b, data: m_word});
          end
          m_left = BEATS;
          m_acc++;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
  end

  int  n_writes = 0;
  wr_t e;

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("we", ram_we, m_left > 0);
      chk("busy", busy, m_left > 0);
      chk("feedback", ram_feedback, m_fb);
      chk("overrun", overrun, m_ovr);
      if (ram_we) n_writes++;
      if (m_left > 0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("addr", ram_addr, e.addr);
        chk("wdata", ram_wdata, e.data);
      end
    end
  end

  task automatic randomize_ofm();
    for (int i = 0; i < DSP_NO; i++) ofm[i] = WIDTH'($urandom);
  endtask

  task automatic pulse();
    sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_wdata"}, ram_wdata, 0);
    chk({tag, "_we"}, ram_we, 0);
    chk({tag, "_fb"}, ram_feedback, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovr"}, overrun, 0);
  endtask

  int busy_cnt;
  int mode;
  int bsel;
  int writes_before;

  initial begin
    for (int i = 0; i < DSP_NO; i++) ofm[i] = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Pixel 0 with ofm[i] = i.
    for (int i = 0; i < DSP_NO; i++) ofm[i] = WIDTH'(i);
    pulse();
    randomize_ofm();
    chk("first_addr", ram_addr, 0);
    chk("first_word", ram_wdata, 64'h0003_0002_0001_0000);
    busy_cnt = 0;
    for (int i = 0; i < 110; i++) begin
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    chk("busy_len", busy_cnt, BEATS);

    // Pixels 1..63: nominal period, back-to-back, or with an overrun strobe.
    for (int p = 1; p < NPIX; p++) begin
      randomize_ofm();
      pulse();
      randomize_ofm();
      if (p == 1)      mode = 1;
      else if (p == 2) mode = 2;
      else             mode = int'($urandom_range(0, 2));
      case (mode)
        0: repeat (112) @(negedge clk);
        1: repeat (91) @(negedge clk);
        default: begin
          bsel = int'($urandom_range(0, 89));
          repeat (bsel) @(negedge clk);
          pulse();
          randomize_ofm();
          repeat (90 - bsel + int'($urandom_range(0, 21))) @(negedge clk);
        end
      endcase
    end
    repeat (120) @(negedge clk);
    chk("fb_final", ram_feedback, 1);
    chk("writes_total", n_writes, NPIX * BEATS);
    chk("queue_empty", exp_q.size(), 0);
    chk("ovr_seen", overrun, 1);

    // Strobe after completion must be ignored.
    writes_before = n_writes;
    randomize_ofm();
    pulse();
    repeat (10) @(negedge clk);
    chk("post_done_writes", n_writes, writes_before);
    chk("post_done_fb", ram_feedback, 1);

    // Reset in the middle of pixel 3, beat 50.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      randomize_ofm();
      pulse();
      repeat (112) @(negedge clk);
    end
    chk("no_ovr_nominal", overrun, 0);
    randomize_ofm();
    pulse();
    repeat (50) @(negedge clk);
    chk("mid_addr", ram_addr, 3 * BEATS + 50);
    #1 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    randomize_ofm();
    pulse();
    chk("restart_addr", ram_addr, 0);
    chk("restart_we", ram_we, 1);
    repeat (100) @(negedge clk);
    chk("restart_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fire9_expand1_ofm_writer.md
# fire9_expand1_ofm_writer

Output-side drain for the fire9 expand-1x1 layer. Captures the DSP_NO-wide output bank each time the layer raises `fire9_expand1_sample` and serializes it as LANES-channel words into the output feature-map RAM. After the last of WOUT² pixels is written, it raises `ram_feedback` back to the layer, which releases `fire9_expand1_finish` handshaking for the next stage.

## Interface
- WOUT, 8, output spatial dimension; the block accepts exactly WOUT² samples
- DSP_NO, 368, channels per sample
- WIDTH, 16, bits per channel
- LANES, 4, channels per RAM word; DSP_NO % LANES == 0 is required
- BEATS, DSP_NO/LANES (92), derived; RAM words per pixel
- ADDR_W, $clog2(WOUT²·BEATS) (13), derived
- clk  in  1  clock; all flops rise-edge
- rst  in  1  reset, asynchronous, active-low
- fire9_expand1_sample  in  1  one-cycle strobe; `ofm` is valid in the same cycle
- ofm  in  WIDTH × [0:DSP_NO-1]  layer output bank, unpacked array
- ram_addr  out  ADDR_W  write word address
- ram_wdata  out  LANES·WIDTH  lane k occupies bits [k·WIDTH +: WIDTH], where lane k carries channel beat·LANES+k
- ram_we  out  1  write enable
- ram_feedback  out  1  sticky high once all pixels are written
- busy  out  1  high in WRITE
- overrun  out  1  sticky error flag: a sample arrived while the previous one was still draining

## Operation
- FSM states: IDLE, WRITE, DONE.
- IDLE
  - When `sample` is high and pix_cnt < WOUT², copy `ofm` into the shadow bank, set beat=0, and go to WRITE.
- WRITE
  - Each cycle: `ram_we`=1, `ram_addr` = pix_cnt·BEATS + beat, `ram_wdata` = shadow[beat·LANES +: LANES].
  - On beat = BEATS-1: increment pix_cnt.
    - If the new pix_cnt == WOUT², go to DONE.
    - Otherwise, if `sample` is high in this same cycle, recapture the shadow, set beat=0, and stay in WRITE (back-to-back, no overrun).
    - Otherwise go to IDLE.
  - `sample` on any other beat: set `overrun`, drop the sample, leave pix_cnt unchanged, and keep draining the current pixel.
- DONE
  - `ram_feedback`=1 and `ram_we`=0.
  - All further samples are ignored; they set no overrun.
  - The state is held until reset.
- Arithmetic: the address is computed with an incremental base register (base += BEATS per pixel), not a multiplier. The address never wraps because DONE is entered first.
- The shadow bank is written only on an accepted capture, so `ofm` may change freely after the strobe.

## Timing
- Reset values: `ram_addr`=0, `ram_wdata`=0, `ram_we`=0, `ram_feedback`=0, `busy`=0, `overrun`=0. Internally state=IDLE and pix_cnt=beat=0.
- Accepted sample at edge t: the first write (beat 0) is presented in cycle t+1, and the last beat in cycle t+BEATS.
- `ram_we`, `ram_addr` and `ram_wdata` are registered outputs. The RAM samples them on the next rising edge.
- `ram_feedback` rises in the cycle after the final beat of pixel WOUT²-1.
- Throughput requirement: the sample period (CHIN+1 = 113 cycles for fire9) must be ≥ BEATS. With BEATS=92 there is 21 cycles of slack.
- Reset asserted mid-operation: all outputs and state clear asynchronously. A partially written pixel is abandoned, and pix_cnt restarts at 0 after reset release.

## Structure
- Shared package `fire9_pkg`:
  - fsm state enum `wr_state_t`
  - constants WOUT, DSP_NO, WIDTH, LANES
  - localparam BEATS
- Natural sub-module: `ofm_lane_mux`, a combinational selector from the shadow bank to one LANES-wide word indexed by beat. The top level holds the FSM, counters and shadow registers.

## Test plan
- Reset then a single sample with ofm[i]=i → 92 writes at addresses 0..91. The word at address 0 = {16'd3,16'd2,16'd1,16'd0}, and address 91 holds channels 364..367. `busy` is high for exactly 92 cycles.
- 64 samples, 113-cycle period, ofm[i]=pix·1000+i → 5888 writes at contiguous addresses 0..5887 with no overrun. `ram_feedback` rises 1 cycle after the write to address 5887 and stays high.
- Sample on beat 91 of pixel 0 → beat 0 of pixel 1 appears at address 92 the next cycle, with no idle gap and `overrun`=0.
- Sample on beat 40 → `overrun`=1; pixel 0 data is unchanged through address 91 and pix_cnt stays at 1. The next valid sample writes to address 92.
- Samples after DONE (a 65th strobe) → no writes and `overrun` stays 0.
- Reset asserted on beat 50 of pixel 3 → all outputs are 0 immediately. After release, a new sample writes beginning at address 0.
